// File: rtl/dmem_responder_if.sv
// Request/response channel between a pipeline memory stage (master) and
// dmem_responder (slave): valid/ready request in, registered response out.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory: one word request at a time, registered
// response held until taken. Optional DMEM_BOUNDS_CHECK_EN flags out-of-range addresses.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] rsp_data_q;
  logic        accept;
  logic        in_range;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign idx = bus.req_addr[AW-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  logic rsp_err_q;

  assign in_range    = (bus.req_addr < 32'(DEPTH));
  assign bus.rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err_q <= 1'b0;
    else if (accept) rsp_err_q <= !in_range;
  end
`else
  assign in_range    = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_data = rsp_data_q;

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;

    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.req_ready = bus.rsp_ready;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt    = RESP;
        else                wait_cnt_nxt = wait_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase

    accept = bus.req_valid && bus.req_ready;
    // An accept (from IDLE or back-to-back out of RESP) overrides the RESP->IDLE exit.
    if (accept) begin
      state_nxt    = (LATENCY == 1) ? RESP : WAIT;
      wait_cnt_nxt = WAIT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rsp_data_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept)
        rsp_data_q <= (bus.req_write || !in_range) ? '0 : mem[idx];
    end
  end

  // Memory array has no reset so an accepted write survives a later reset pulse.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && in_range)
      mem[idx] <= bus.req_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: two instances
// (DEPTH=256/LATENCY=2 and DEPTH=16/LATENCY=1) checked against an array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        busy0, busy1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_mem   [2][256];
  bit          model_known [2][256];

  dmem_responder_if b0();
  dmem_responder_if b1();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .busy(busy0)
  );
  dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1)
  );

  assign b0.req_valid = req_valid && (sel == 0);
  assign b1.req_valid = req_valid && (sel == 1);
  assign b0.req_write = req_write;
  assign b1.req_write = req_write;
  assign b0.req_addr  = req_addr;
  assign b1.req_addr  = req_addr;
  assign b0.req_wdata = req_wdata;
  assign b1.req_wdata = req_wdata;
  assign b0.rsp_ready = rsp_ready;
  assign b1.rsp_ready = rsp_ready;

  logic        o_ready, o_valid, o_err, o_busy;
  logic [31:0] o_data;
  assign o_ready = sel ? b1.req_ready : b0.req_ready;
  assign o_valid = sel ? b1.rsp_valid : b0.rsp_valid;
  assign o_err   = sel ? b1.rsp_err   : b0.rsp_err;
  assign o_data  = sel ? b1.rsp_data  : b0.rsp_data;
  assign o_busy  = sel ? busy1        : busy0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int cfg_depth(input int s);
    return (s == 1) ? 16 : 256;
  endfunction

  function automatic int cfg_lat(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  // One complete transaction from IDLE; call at a negedge. hold = cycles with
  // rsp_ready low while the response is presented; rst_wait pulses reset in WAIT.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, input bit rst_wait);
    int          dep, lat, n, ix;
    bit          inr, known;
    logic [31:0] exp_data;
    logic        exp_err;
    dep = cfg_depth(sel);
    lat = cfg_lat(sel);
    ix  = int'(addr % 32'(dep));
`ifdef DMEM_BOUNDS_CHECK_EN
    inr = (addr < 32'(dep));
`else
    inr = 1'b1;
`endif
    exp_err  = !inr;
    known    = wr || !inr || model_known[sel][ix];
    exp_data = (wr || !inr) ? 32'h0 : model_mem[sel][ix];

    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      check("req_ready_timeout", 32'(n), 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (wr && inr) begin
      model_mem[sel][ix]   = wd;
      model_known[sel][ix] = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 1;

    if (rst_wait && !o_valid) begin
      check("wait_req_ready", 32'(o_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(o_valid), 32'd0);
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      check("rst_mid_ready", 32'(o_ready), 32'd1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      return;
    end

    while (!o_valid && n < 50) begin
      check("wait_req_ready", 32'(o_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    if (!o_valid) return;
    if (known) check("rsp_data", o_data, exp_data);
    check("rsp_err", 32'(o_err), 32'(exp_err));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      if (known) check("bp_data", o_data, exp_data);
      check("bp_err", 32'(o_err), 32'(exp_err));
      check("bp_req_ready", 32'(o_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("resp_req_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_valid", 32'(o_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) model_known[s][i] = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("rst_req_ready", 32'(o_ready), 32'd1);
      check("rst_rsp_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_rsp_data", o_data, 32'h0);
      check("rst_rsp_err", 32'(o_err), 32'd0);
    end
    @(negedge clk);

    // Write then read, LATENCY=2; then backpressure on a read.
    sel = 0;
    xact(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0);
    xact(1'b0, 32'd5, 32'h0, 0, 1'b0);
    xact(1'b0, 32'd5, 32'h0, 4, 1'b0);

    // Back-to-back at LATENCY=1.
    sel = 1;
    xact(1'b1, 32'd7, 32'h12345678, 0, 1'b0);
    req_write = 1'b0; req_addr = 32'd4; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_first_valid", 32'(o_valid), 32'd1);
    rsp_ready = 1'b1;
    req_addr  = 32'd7;
    #1;
    check("b2b_accept", 32'(o_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_valid", 32'(o_valid), 32'd1);
    check("b2b_data", o_data, 32'h12345678);
    check("b2b_busy", 32'(o_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle", 32'(o_busy), 32'd0);
    rsp_ready = 1'b0;

    // Reset during the WAIT of a write; the write must stay committed.
    sel = 0;
    xact(1'b1, 32'd3, 32'hA5A5A5A5, 0, 1'b1);
    xact(1'b0, 32'd3, 32'h0, 0, 1'b0);

    // Address 256 on a 256-word instance: error or wrap depending on build.
    xact(1'b1, 32'd0, 32'hCAFEF00D, 0, 1'b0);
    xact(1'b1, 32'd256, 32'h1, 0, 1'b0);
    xact(1'b0, 32'd0, 32'h0, 0, 1'b0);

    // Random traffic on both instances, including out-of-range and wrapped addresses.
    for (int i = 0; i < 150; i++) begin
      int          dep;
      logic [31:0] a;
      sel = int'($urandom_range(0, 1));
      dep = cfg_depth(sel);
      a   = 32'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = a + 32'(dep);
        1: a = a + 32'(dep) * 32'($urandom_range(2, 40));
        2: a = $urandom;
        default: ;
      endcase
      xact(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
